// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the burst RAM controller: FSM state encoding and default widths.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_one_port.sv
// Single-port RAM: synchronous write, combinational read of the addressed word.
module ram_one_port #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller: accepts write/read commands and streams beats to/from a single-port RAM
// with valid/ready back-pressure on the command, write-data and read-data channels.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  beats_left_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;

  logic cmd_hs_s;
  logic wr_hs_s;
  logic rd_cap_s;

  // A read beat is only fetched when the single output slot is empty or being drained.
  assign cmd_hs_s = (state_q == ST_IDLE) && cmd_valid;
  assign wr_hs_s  = (state_q == ST_WRITE) && wdata_valid;
  assign rd_cap_s = (state_q == ST_READ) && (!rdata_valid_q || rdata_ready);

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wdata_ready = (state_q == ST_WRITE);
  assign ram_wr_en   = wr_hs_s;
  assign ram_wr_data = wdata;
  assign ram_addr    = cur_addr_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = (state_q != ST_IDLE) || rdata_valid_q;

  // Burst sequencing FSM plus the read-data output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      beats_left_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_hs_s) begin
            cur_addr_q   <= cmd_addr;
            beats_left_q <= cmd_len;
            state_q      <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_hs_s) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            if (beats_left_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              beats_left_q <= beats_left_q - LEN_W'(1);
            end
          end
        end
        ST_READ: begin
          if (rd_cap_s) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            if (beats_left_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              beats_left_q <= beats_left_q - LEN_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // A pending beat survives IDLE until consumed, so the slot is managed outside the case.
      if (rd_cap_s) begin
        rdata_q       <= ram_rd_data;
        rdata_valid_q <= 1'b1;
      end else if (rdata_ready) begin
        rdata_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed self-checking bench: ram_burst_ctrl driving ram_one_port end to end.
module tb_ram_burst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [1:0] cmd_len;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic       rdata_ready;
  logic [7:0] rdata;
  logic       busy;
  logic [1:0] ram_addr;
  logic       ram_wr_en;
  logic [7:0] ram_wr_data;
  logic [7:0] ram_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  ram_burst_ctrl #(.ADDR_W(2), .DATA_W(8), .LEN_W(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  ram_one_port #(.ADDR_W(2), .DATA_W(8)) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .wr_en   (ram_wr_en),
    .wr_data (ram_wr_data),
    .rd_data (ram_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd0;
    wdata_valid = 1'b0; wdata = 8'h3C; rdata_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    n_checks++; if (wdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_ready got %b exp 0", wdata_ready); end
    n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid got %b exp 0", rdata_valid); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (ram_addr !== 2'd0) begin n_fail++; $display("FAIL reset_ram_addr got %0d exp 0", ram_addr); end
    n_checks++; if (ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wr_en got %b exp 0", ram_wr_en); end
    n_checks++; if (ram_wr_data !== 8'h3C) begin n_fail++; $display("FAIL reset_wr_data_pass got %h exp 3c", ram_wr_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_burst;
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_len = 2'd3; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = d[k]; #1;
      n_checks++; if (ram_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_en beat %0d got %b exp 1", k, ram_wr_en); end
      n_checks++; if (ram_addr !== 2'(k)) begin n_fail++; $display("FAIL wr_addr beat %0d got %0d exp %0d", k, ram_addr, k); end
      n_checks++; if (wdata_ready !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready beat %0d got wr=%b cmd=%b exp wr=1 cmd=0", k, wdata_ready, cmd_ready); end
    end
    @(negedge clk); wdata_valid = 1'b0; #1;
    n_checks++; if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_done got cmd=%b wr=%b busy=%b exp 1 0 0", cmd_ready, wdata_ready, busy); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (u_ram.mem[k] !== d[k]) begin n_fail++; $display("FAIL wr_mem[%0d] got %h exp %h", k, u_ram.mem[k], d[k]); end
    end
  endtask

  task automatic test_read_burst;
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd3; rdata_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; #1;
    n_checks++; if (rdata_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_latency got valid=%b busy=%b exp 0 1", rdata_valid, busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++; if (rdata_valid !== 1'b1 || rdata !== d[k]) begin n_fail++; $display("FAIL rd_beat %0d got valid=%b data=%h exp 1 %h", k, rdata_valid, rdata, d[k]); end
    end
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_done got valid=%b cmd=%b busy=%b exp 0 1 0", rdata_valid, cmd_ready, busy); end
  endtask

  task automatic test_wrap;
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_len = 2'd1;
    @(negedge clk); cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 8'hA5; #1;
    n_checks++; if (ram_wr_en !== 1'b1 || ram_addr !== 2'd3) begin n_fail++; $display("FAIL wrap_beat0 got en=%b addr=%0d exp 1 3", ram_wr_en, ram_addr); end
    @(negedge clk); wdata_valid = 1'b0; wdata = 8'hFF; #1;
    n_checks++; if (ram_wr_en !== 1'b0 || ram_addr !== 2'd0 || wdata_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_stall got en=%b addr=%0d rdy=%b exp 0 0 1", ram_wr_en, ram_addr, wdata_ready); end
    @(negedge clk); wdata_valid = 1'b1; wdata = 8'h5A; #1;
    n_checks++; if (ram_wr_en !== 1'b1 || ram_addr !== 2'd0) begin n_fail++; $display("FAIL wrap_beat1 got en=%b addr=%0d exp 1 0", ram_wr_en, ram_addr); end
    @(negedge clk); wdata_valid = 1'b0; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_cmd_ready got %b exp 1", cmd_ready); end
    n_checks++; if (u_ram.mem[3] !== 8'hA5 || u_ram.mem[0] !== 8'h5A) begin n_fail++; $display("FAIL wrap_mem got m3=%h m0=%h exp a5 5a", u_ram.mem[3], u_ram.mem[0]); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; cmd_len = 2'd1; rdata_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'hA5) begin n_fail++; $display("FAIL wrap_rd0 got valid=%b data=%h exp 1 a5", rdata_valid, rdata); end
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'h5A) begin n_fail++; $display("FAIL wrap_rd1 got valid=%b data=%h exp 1 5a", rdata_valid, rdata); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_done busy got %b exp 0", busy); end
  endtask

  task automatic test_read_stall;
    logic [7:0] expd [4];
    logic       pat [4];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [1:0] prev_addr;
    int         got;
    expd = '{8'h5A, 8'h22, 8'h33, 8'hA5};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    prev_stall = 1'b0; prev_data = 8'h00; prev_addr = 2'd0; got = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd3; rdata_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk); cmd_valid = 1'b0; rdata_ready = pat[cyc % 4]; #1;
      if (prev_stall) begin
        n_checks++; if (rdata_valid !== 1'b1 || rdata !== prev_data || ram_addr !== prev_addr) begin n_fail++; $display("FAIL stall_hold got valid=%b data=%h addr=%0d exp 1 %h %0d", rdata_valid, rdata, ram_addr, prev_data, prev_addr); end
      end
      if (rdata_valid && rdata_ready) begin
        n_checks++; if (rdata !== expd[got]) begin n_fail++; $display("FAIL stall_beat %0d got %h exp %h", got, rdata, expd[got]); end
        got++;
      end
      prev_stall = rdata_valid && !rdata_ready;
      prev_data  = rdata;
      prev_addr  = ram_addr;
    end
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL stall_count got %0d exp 4", got); end
    rdata_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done got busy=%b valid=%b exp 0 0", busy, rdata_valid); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1; cmd_len = 2'd0; rdata_ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 2'd2; #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'h22 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pending got valid=%b data=%h cmd=%b exp 1 22 1", rdata_valid, rdata, cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0; #1;
    n_checks++; if (rdata !== 8'h22 || cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_held got data=%h cmd=%b busy=%b exp 22 0 1", rdata, cmd_ready, busy); end
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'h22) begin n_fail++; $display("FAIL b2b_held2 got valid=%b data=%h exp 1 22", rdata_valid, rdata); end
    rdata_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'h33 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second got valid=%b data=%h cmd=%b exp 1 33 1", rdata_valid, rdata, cmd_ready); end
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done got valid=%b busy=%b exp 0 0", rdata_valid, busy); end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_len = 2'd3;
    @(negedge clk); cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 8'h01;
    @(negedge clk); wdata = 8'h02; #1;
    n_checks++; if (ram_wr_en !== 1'b1 || ram_addr !== 2'd1) begin n_fail++; $display("FAIL rstmid_beat2 got en=%b addr=%0d exp 1 1", ram_wr_en, ram_addr); end
    #1 rst_n = 1'b0; #1;
    n_checks++; if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0 || ram_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got cmd=%b wr=%b en=%b exp 1 0 0", cmd_ready, wdata_ready, ram_wr_en); end
    n_checks++; if (busy !== 1'b0 || ram_addr !== 2'd0 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got busy=%b addr=%0d valid=%b exp 0 0 0", busy, ram_addr, rdata_valid); end
    @(negedge clk); wdata_valid = 1'b0; rst_n = 1'b1; #1;
    n_checks++; if (u_ram.mem[0] !== 8'h01 || u_ram.mem[1] !== 8'h22) begin n_fail++; $display("FAIL rstmid_mem01 got %h %h exp 01 22", u_ram.mem[0], u_ram.mem[1]); end
    n_checks++; if (u_ram.mem[2] !== 8'h33 || u_ram.mem[3] !== 8'hA5) begin n_fail++; $display("FAIL rstmid_mem23 got %h %h exp 33 a5", u_ram.mem[2], u_ram.mem[3]); end
    @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd0; rdata_ready = 1'b1; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready got %b exp 1", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rdata_valid !== 1'b1 || rdata !== 8'h01) begin n_fail++; $display("FAIL rstmid_read got valid=%b data=%h exp 1 01", rdata_valid, rdata); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
